counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Command-driven controller that sequences the team's N-bit load/inc/dec/shift counter.
- Accepts one command at a time over a valid/ready handshake and expands it into a timed train of single-cycle control strobes (L, INC, DEC, SHL, SHR) plus data D.
- Reports completion and error status.
- Sits between a host/FSM and the counter instance; observes the counter output Q for conditional runs.

Parameters:
N, 4, counter data width (must match the driven counter, N >= 2)
REP_W, 4, width of the repeat-count field

Ports:
C  input  1  clock, all logic on posedge C
R  input  1  reset, synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  opcode: 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 SHL, 5 SHR, 6 RUN_UNTIL, 7 reserved
cmd_arg  input  N  load value / serial-in source / RUN_UNTIL target
cmd_rep  input  REP_W  step count for INC/DEC/SHL/SHR
abort  input  1  terminate current command
q_in  input  N  counter Q, fed back
ctr_D  output  N  counter D
ctr_L, ctr_INC, ctr_DEC, ctr_SHL, ctr_SHR  output  1 each  counter control strobes
busy  output  1  command in progress
done  output  1  one-cycle completion pulse
err  output  1  valid with done: timeout, abort or reserved opcode

Behaviour:
- Reset (R=1 at posedge C): state IDLE; all strobes 0; ctr_D=0; done=0; err=0; busy=0; latched command and step counter cleared. R has priority over every other input. A mid-command reset drops the command with no done.
- At most one ctr_* strobe is high in any cycle. Strobes are registered outputs.
- States: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1, busy=0. Accept when cmd_valid and cmd_ready at a posedge; latch op, arg and rep, then go to EXEC. If no command is accepted, stay in IDLE.
- EXEC: cmd_ready=0, busy=1. ctr_D holds the latched arg for the whole command.
  - LOAD: ctr_L=1 for exactly 1 cycle, then DONE; rep is ignored.
  - INC/DEC/SHL/SHR: the matching strobe is high for exactly rep consecutive cycles, then DONE.
  - rep=0: no strobe; EXEC lasts 1 cycle, then DONE with err=0.
  - NOP: 1 EXEC cycle, no strobe, then DONE.
  - RUN_UNTIL: each EXEC cycle compares q_in with arg.
    - Equal: ctr_INC=0 that cycle, go to DONE, err=0.
    - Not equal: ctr_INC=1 and the timeout counter increments.
    - After 2^N strobes without a match: go to DONE with err=1.
  - Reserved op 7: 1 EXEC cycle, no strobe, then DONE with err=1.
  - abort=1 in EXEC: all strobes 0 in that same registered update; go to DONE with err=1. abort is ignored in IDLE and DONE.
- DONE: done=1 for exactly 1 cycle; err valid in that cycle, 0 otherwise; busy=0, cmd_ready=0; next state IDLE.
- Latency: command accepted at edge k → strobes high in cycles k+1..k+rep → done in cycle k+rep+1 → cmd_ready in cycle k+rep+2. Back-to-back throughput is rep+2 cycles per command.
- cmd_valid held high in DONE is accepted only once the sequencer returns to IDLE; no command is lost or duplicated.
- Step and timeout counters are REP_W and N+1 bits wide; neither wraps before terminating.
- Fields of cmd_* are sampled only at acceptance; later changes have no effect.

Test Plan:
- Reset then LOAD arg=4'hA: ctr_L high 1 cycle with ctr_D=4'hA; done the next cycle; counter Q=4'hA; cmd_ready back 1 cycle later.
- INC rep=5 from Q=4'hE: ctr_INC high exactly 5 consecutive cycles, no other strobe; done with err=0; counter Q matches its own wrap rule.
- SHL rep=3 arg[0]=1 from Q=4'h0: Q goes 1, 3, 7; SHR rep=2 arg[3]=1 from Q=4'h0: Q goes 8, C; rep=0 gives no strobe and done 1 cycle after accept.
- RUN_UNTIL arg=4'h6 from Q=4'h2: exactly 4 INC strobes, done with err=0. With the counter held so Q never matches: 16 strobes, then done with err=1.
- DEC rep=10 with abort asserted on the 3rd strobe cycle: only 2 DEC strobes; done with err=1 on the next cycle. R asserted mid-INC: strobes 0 and IDLE at the next edge, no done.
- cmd_valid held high with two queued commands (INC rep=1, DEC rep=1): each is accepted once; cmd_ready is 0 during EXEC and DONE; strobes never overlap.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: expands one host command into a timed train of registered counter strobes.
module counter_sequencer #(
  parameter int N = 4,
  parameter int REP_W = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [N-1:0]     cmd_arg,
  input  logic [REP_W-1:0] cmd_rep,
  input  logic             abort,
  input  logic [N-1:0]     q_in,
  output logic [N-1:0]     ctr_D,
  output logic             ctr_L,
  output logic             ctr_INC,
  output logic             ctr_DEC,
  output logic             ctr_SHL,
  output logic             ctr_SHR,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [N:0] TMAX = (N+1)'(1) << N;
  state_t state, state_n;
  logic [2:0] op, op_n;
  logic [N-1:0] arg, arg_n;
  logic [REP_W-1:0] cnt, cnt_n;
  logic [N:0] tcnt, tcnt_n;
  logic [4:0] stb, stb_n, sel;
  logic err_q, err_n, hit;
  assign sel = (cmd_op == 3'd6) ? 5'b00010 :
               (cmd_op != 3'd0 && cmd_op != 3'd7) ? 5'b00001 << (cmd_op - 3'd1) : 5'b00000;
  // Q lags the registered INC strobe by one edge, so compare against the value it is about to take
  assign hit = (q_in + N'(stb[1])) == arg;
  always_comb begin
    state_n = state;
    op_n = op;
    arg_n = arg;
    cnt_n = cnt;
    tcnt_n = tcnt;
    stb_n = '0;
    err_n = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        state_n = EXEC;
        op_n = cmd_op;
        arg_n = cmd_arg;
        cnt_n = (cmd_op != 3'd1 && cmd_op != 3'd6 && sel != '0 && cmd_rep != '0) ? cmd_rep - REP_W'(1) : '0;
        stb_n = (cmd_op == 3'd6) ? ((q_in == cmd_arg) ? '0 : sel) :
                (cmd_op == 3'd1 || cmd_rep != '0) ? sel : '0;
        tcnt_n = (cmd_op == 3'd6 && q_in != cmd_arg) ? (N+1)'(1) : '0;
      end
      EXEC: if (abort) begin
        state_n = DONE;
        err_n = 1'b1;
      end else if (op == 3'd6) begin
        if (hit) state_n = DONE;
        else if (tcnt == TMAX) begin
          state_n = DONE;
          err_n = 1'b1;
        end else begin
          stb_n = 5'b00010;
          tcnt_n = tcnt + (N+1)'(1);
        end
      end else if (cnt != '0) begin
        stb_n = stb;
        cnt_n = cnt - REP_W'(1);
      end else begin
        state_n = DONE;
        err_n = (op == 3'd7);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge C) begin
    if (R) begin
      state <= IDLE;
      op <= '0;
      arg <= '0;
      cnt <= '0;
      tcnt <= '0;
      stb <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      op <= op_n;
      arg <= arg_n;
      cnt <= cnt_n;
      tcnt <= tcnt_n;
      stb <= stb_n;
      err_q <= err_n;
    end
  end
  assign {ctr_SHR, ctr_SHL, ctr_DEC, ctr_INC, ctr_L} = stb;
  assign ctr_D = arg;
  assign cmd_ready = state == IDLE;
  assign busy = state == EXEC;
  assign done = state == DONE;
  assign err = err_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed bench driving the sequencer into a behavioural model of the counter.
module tb_counter_sequencer;
  logic C = 1'b0, R = 1'b1;
  logic cmd_valid = 1'b0, abort = 1'b0, hold = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_arg = '0, cmd_rep = '0, q = '0;
  logic cmd_ready, ctr_L, ctr_INC, ctr_DEC, ctr_SHL, ctr_SHR, busy, done, err;
  logic [3:0] ctr_D;
  int errors = 0, checks = 0, overlap = 0;
  int n_l, n_inc, n_dec, n_shl, n_shr, first_s, last_s, lat;
  logic e_done, rdy_after;
  logic [3:0] d_stb;
  logic [3:0] qs [0:40];

  counter_sequencer #(.N(4), .REP_W(4)) dut (
    .C(C), .R(R), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .cmd_rep(cmd_rep), .abort(abort), .q_in(q), .ctr_D(ctr_D),
    .ctr_L(ctr_L), .ctr_INC(ctr_INC), .ctr_DEC(ctr_DEC), .ctr_SHL(ctr_SHL), .ctr_SHR(ctr_SHR),
    .busy(busy), .done(done), .err(err));

  always #5 C = ~C;

  always @(posedge C)
    if (!hold)
      q <= ctr_L ? ctr_D : ctr_INC ? q + 4'd1 : ctr_DEC ? q - 4'd1 :
           ctr_SHL ? {q[2:0], ctr_D[0]} : ctr_SHR ? {ctr_D[3], q[3:1]} : q;

  always @(negedge C)
    if (32'(ctr_L) + 32'(ctr_INC) + 32'(ctr_DEC) + 32'(ctr_SHL) + 32'(ctr_SHR) > 1) overlap++;

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] arg, input logic [3:0] rep);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_rep = rep;
    tick;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 4'h0; cmd_rep = 4'h0;
    n_l = 0; n_inc = 0; n_dec = 0; n_shl = 0; n_shr = 0;
    first_s = 0; last_s = 0; lat = 0; e_done = 1'bx; d_stb = 4'hx;
    for (int i = 1; i <= 40; i++) begin
      qs[i] = q;
      if (done) begin
        lat = i;
        e_done = err;
        break;
      end
      if (ctr_L | ctr_INC | ctr_DEC | ctr_SHL | ctr_SHR) begin
        if (first_s == 0) first_s = i;
        last_s = i;
        d_stb = ctr_D;
      end
      n_l += 32'(ctr_L); n_inc += 32'(ctr_INC); n_dec += 32'(ctr_DEC);
      n_shl += 32'(ctr_SHL); n_shr += 32'(ctr_SHR);
      tick;
    end
    tick;
    rdy_after = cmd_ready;
  endtask

  task automatic test_reset;
    R = 1'b1;
    tick; tick;
    R = 1'b0;
    checks++;
    if ({cmd_ready, busy, done, err, ctr_L, ctr_INC, ctr_DEC, ctr_SHL, ctr_SHR, ctr_D} !== 13'h1000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h",
        {cmd_ready, busy, done, err, ctr_L, ctr_INC, ctr_DEC, ctr_SHL, ctr_SHR, ctr_D}, 13'h1000);
    end
  endtask

  task automatic test_load;
    run_cmd(3'd1, 4'hA, 4'd7);
    checks++;
    if ({n_l, n_inc + n_dec + n_shl + n_shr, first_s} !== {32'd1, 32'd0, 32'd1}) begin
      errors++; $display("FAIL load_strobes: got L=%0d other=%0d first=%0d expected 1 0 1", n_l, n_inc + n_dec + n_shl + n_shr, first_s);
    end
    checks++;
    if (d_stb !== 4'hA) begin errors++; $display("FAIL load_D: got %h expected a", d_stb); end
    checks++;
    if ({lat, e_done, rdy_after} !== {32'd2, 1'b0, 1'b1}) begin
      errors++; $display("FAIL load_timing: got lat=%0d err=%b rdy=%b expected 2 0 1", lat, e_done, rdy_after);
    end
    checks++;
    if (q !== 4'hA) begin errors++; $display("FAIL load_Q: got %h expected a", q); end
  endtask

  task automatic test_inc;
    run_cmd(3'd1, 4'hE, 4'd0);
    run_cmd(3'd2, 4'h0, 4'd5);
    checks++;
    if ({n_inc, first_s, last_s, n_l + n_dec + n_shl + n_shr} !== {32'd5, 32'd1, 32'd5, 32'd0}) begin
      errors++; $display("FAIL inc_strobes: got inc=%0d first=%0d last=%0d other=%0d expected 5 1 5 0", n_inc, first_s, last_s, n_l + n_dec + n_shl + n_shr);
    end
    checks++;
    if ({lat, e_done, q} !== {32'd6, 1'b0, 4'h3}) begin
      errors++; $display("FAIL inc_done: got lat=%0d err=%b Q=%h expected 6 0 3", lat, e_done, q);
    end
  endtask

  task automatic test_shift;
    run_cmd(3'd1, 4'h0, 4'd0);
    run_cmd(3'd4, 4'h1, 4'd3);
    checks++;
    if ({n_shl, qs[2], qs[3], qs[4], lat} !== {32'd3, 4'h1, 4'h3, 4'h7, 32'd4}) begin
      errors++; $display("FAIL shl_seq: got n=%0d Q=%h,%h,%h lat=%0d expected 3 1,3,7 4", n_shl, qs[2], qs[3], qs[4], lat);
    end
    run_cmd(3'd1, 4'h0, 4'd0);
    run_cmd(3'd5, 4'h8, 4'd2);
    checks++;
    if ({n_shr, qs[2], qs[3], lat} !== {32'd2, 4'h8, 4'hC, 32'd3}) begin
      errors++; $display("FAIL shr_seq: got n=%0d Q=%h,%h lat=%0d expected 2 8,c 3", n_shr, qs[2], qs[3], lat);
    end
    run_cmd(3'd3, 4'h0, 4'd0);
    checks++;
    if ({n_l + n_inc + n_dec + n_shl + n_shr, lat, e_done} !== {32'd0, 32'd2, 1'b0}) begin
      errors++; $display("FAIL rep0: got strobes=%0d lat=%0d err=%b expected 0 2 0", n_l + n_inc + n_dec + n_shl + n_shr, lat, e_done);
    end
    run_cmd(3'd0, 4'h0, 4'd9);
    checks++;
    if ({n_l + n_inc + n_dec + n_shl + n_shr, lat, e_done} !== {32'd0, 32'd2, 1'b0}) begin
      errors++; $display("FAIL nop: got strobes=%0d lat=%0d err=%b expected 0 2 0", n_l + n_inc + n_dec + n_shl + n_shr, lat, e_done);
    end
    run_cmd(3'd7, 4'h0, 4'd3);
    checks++;
    if ({n_l + n_inc + n_dec + n_shl + n_shr, lat, e_done} !== {32'd0, 32'd2, 1'b1}) begin
      errors++; $display("FAIL reserved: got strobes=%0d lat=%0d err=%b expected 0 2 1", n_l + n_inc + n_dec + n_shl + n_shr, lat, e_done);
    end
  endtask

  task automatic test_run_until;
    run_cmd(3'd1, 4'h2, 4'd0);
    run_cmd(3'd6, 4'h6, 4'd0);
    checks++;
    if ({n_inc, lat, e_done, q} !== {32'd4, 32'd5, 1'b0, 4'h6}) begin
      errors++; $display("FAIL run_match: got inc=%0d lat=%0d err=%b Q=%h expected 4 5 0 6", n_inc, lat, e_done, q);
    end
    run_cmd(3'd6, 4'h6, 4'd0);
    checks++;
    if ({n_inc, lat, e_done} !== {32'd0, 32'd2, 1'b0}) begin
      errors++; $display("FAIL run_already: got inc=%0d lat=%0d err=%b expected 0 2 0", n_inc, lat, e_done);
    end
    hold = 1'b1;
    run_cmd(3'd6, 4'h5, 4'd0);
    hold = 1'b0;
    checks++;
    if ({n_inc, lat, e_done} !== {32'd16, 32'd17, 1'b1}) begin
      errors++; $display("FAIL run_timeout: got inc=%0d lat=%0d err=%b expected 16 17 1", n_inc, lat, e_done);
    end
  endtask

  task automatic test_abort;
    int nd = 0;
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_rep = 4'd10;
    tick;
    cmd_valid = 1'b0;
    nd += 32'(ctr_DEC);
    tick;
    nd += 32'(ctr_DEC);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    nd += 32'(ctr_DEC);
    checks++;
    if ({nd, done, err} !== {32'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL abort: got dec=%0d done=%b err=%b expected 2 1 1", nd, done, err);
    end
    tick;
    checks++;
    if ({cmd_ready, done, err} !== 3'b100) begin
      errors++; $display("FAIL abort_idle: got rdy/done/err=%b expected 100", {cmd_ready, done, err});
    end
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_rep = 4'd8;
    tick;
    cmd_valid = 1'b0;
    tick;
    R = 1'b1;
    tick;
    checks++;
    if ({ctr_INC, busy, done, cmd_ready} !== 4'b0001) begin
      errors++; $display("FAIL reset_mid: got inc/busy/done/rdy=%b expected 0001", {ctr_INC, busy, done, cmd_ready});
    end
    R = 1'b0;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      nd += 32'(done) + 32'(ctr_INC);
      tick;
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL reset_no_done: got done+inc=%0d expected 0", nd); end
  endtask

  task automatic test_back_to_back;
    int nacc = 0, ni = 0, ndc = 0, ndn = 0, nbad = 0;
    logic acc;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_rep = 4'd1; cmd_arg = 4'h0;
    for (int i = 0; i < 8; i++) begin
      acc = cmd_valid & cmd_ready;
      tick;
      if (acc) begin
        nacc++;
        if (cmd_op == 3'd2) cmd_op = 3'd3;
        else cmd_valid = 1'b0;
      end
      ni += 32'(ctr_INC); ndc += 32'(ctr_DEC); ndn += 32'(done);
      if ((busy | done) & cmd_ready) nbad++;
    end
    cmd_valid = 1'b0;
    checks++;
    if ({nacc, ni, ndc, ndn, nbad} !== {32'd2, 32'd1, 32'd1, 32'd2, 32'd0}) begin
      errors++; $display("FAIL b2b: got acc=%0d inc=%0d dec=%0d done=%0d rdy_bad=%0d expected 2 1 1 2 0", nacc, ni, ndc, ndn, nbad);
    end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", overlap); end
  endtask

  initial begin
    #1;
    test_reset;
    test_load;
    test_inc;
    test_shift;
    test_run_until;
    test_abort;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
